multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Moore-style sequencer that drives the 8-bit RISC-V-subset datapath as a multicycle machine. It replaces per-cycle combinational control with a state machine that sequences fetch, decode, execute, memory and writeback steps over shared ALU and memory resources. It sits beside the register file, ALU, program counter and data memory. It is stepped by an advance enable, so the board can run from the frequency divider or single-step from a key.

## Interface
Parameters:
- none (encodings fixed in shared package)

Ports:
- clock_reg  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low; forces FETCH
- en  in  1  advance enable; state moves and write enables assert only when 1
- OP  in  7  instruction[6:0], valid from DECODE onward (IR held)
- Funct3  in  3  instruction[14:12]
- Funct7_5  in  1  instruction[30]
- Zero  in  1  ALU zero flag
- PCWrite  out  1  PC load enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction/OldPC register load
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rd1
- ALUSrcB  out  2  00 rd2, 01 Imm, 10 constant 4
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc  out  2  00 I, 01 S, 10 B
- state  out  4  current state code, for LEDs
- halted  out  1  1 while in HALT
- instr_done  out  1  1 in the enabled cycle that returns to FETCH

## Operation
- States and codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, BEQ 9, HALT 15.
- Supported opcodes: lw 0000011, sw 0100011, R 0110011, I 0010011, beq 1100011.
- Transitions on en=1:
  - FETCH→DECODE.
  - DECODE→MEMADR (lw/sw), EXECUTER (R), EXECUTEI (I), BEQ (beq), or HALT (any other opcode, or unsupported Funct3).
  - MEMADR→MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD→MEMWB→FETCH.
  - MEMWRITE→FETCH.
  - EXECUTER/EXECUTEI→ALUWB→FETCH.
  - BEQ→FETCH.
  - HALT→HALT until reset.
- Outputs per state; unlisted signals are 0, ALUControl is add:
  - FETCH: AdrSrc 0, IRWrite 1, ALUSrcA 00, ALUSrcB 10, ResultSrc 10, PCUpdate 1.
  - DECODE: ALUSrcA 01, ALUSrcB 01 (branch target precompute).
  - MEMADR: ALUSrcA 10, ALUSrcB 01.
  - MEMREAD: AdrSrc 1, ResultSrc 00.
  - MEMWB: ResultSrc 01, RegWrite 1.
  - MEMWRITE: AdrSrc 1, ResultSrc 00, MemWrite 1.
  - EXECUTER: ALUSrcA 10, ALUSrcB 00, ALU decoded.
  - EXECUTEI: ALUSrcA 10, ALUSrcB 01, ALU decoded.
  - ALUWB: ResultSrc 00, RegWrite 1.
  - BEQ: ALUSrcA 10, ALUSrcB 00, sub, ResultSrc 00, Branch 1.
- PCWrite = en & (PCUpdate | (Branch & Zero)).
- ALU decode:
  - Funct3 000: add, or sub when R-type and Funct7_5=1; Funct7_5 is ignored for I-type.
  - Funct3 010: slt.
  - Funct3 110: or.
  - Funct3 111: and.
  - Any other Funct3 on R/I → HALT.
- ImmSrc is derived from OP in every state: I for lw/I-type, S for sw, B for beq, 00 otherwise.
- HALT: all write enables 0, halted=1.

## Timing
- Reset, whether at power-up or mid-instruction: state=0 immediately (async). All write enables are forced 0 while reset is low. Other outputs take their FETCH values; halted=0, instr_done=0.
- en=0: state holds; PCWrite, IRWrite, RegWrite and MemWrite are 0; mux selects and ALUControl keep current-state values.
- Cycles per instruction, in enabled cycles: beq 3, R/I 4, sw 4, lw 5.
- PCWrite in BEQ depends combinationally on Zero in the same cycle. This is the only Mealy path.
- instr_done = en & (state ∈ {MEMWB, MEMWRITE, ALUWB, BEQ}).
- OP and Funct fields must be stable from DECODE until the return to FETCH. The block does not latch them.

## Structure
- Shared package cpu_ctrl_pkg holds:
  - the state enum (4-bit);
  - opcode constants;
  - ALUControl, ResultSrc, ALUSrcA/B and ImmSrc encodings.
- One sub-module, alu_decoder: combinational, taking OP, Funct3, Funct7_5 and an aluop class (add/sub/funct), returning ALUControl and an illegal flag.
- Main module: state register, next-state logic, output decode, enable gating.

## Test plan
- Reset low mid-MEMREAD, en=1 → state=0 same cycle. RegWrite and MemWrite stay 0 during reset. FETCH controls (IRWrite 1, ALUSrcB 10, PCWrite 1) appear after release.
- lw (OP 0000011) with en=1 every cycle → states 0,1,2,3,4,0. RegWrite=1 and ResultSrc=01 only in state 4. instr_done one pulse.
- R-type sub (Funct3 000, Funct7_5 1) → EXECUTER shows ALUControl 001. Same fields with OP=0010011 → 000 (addi).
- beq in BEQ state: Zero=1 → PCWrite=1; Zero=0 → PCWrite=0. Both cases return to FETCH next cycle.
- en toggled 1,0,0,1 during sw → state holds through the en=0 cycles. MemWrite=1 only in the enabled MEMWRITE cycle.
- OP=1111111 at DECODE → HALT (state 15, halted=1). Stays through 10 enabled cycles; recovers only on reset.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: state codes, opcodes,
// and the mux/ALU select values seen by the datapath.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_BEQ      = 4'd9,
        S_HALT     = 4'd15
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } aluop_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    // Immediate format depends only on the held opcode, never on state.
    function automatic logic [1:0] imm_src_for(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the ALU operation class plus funct fields to an ALUControl code, and
// flags R/I-type instructions whose Funct3 the datapath cannot execute.
module alu_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic [1:0] alu_op,
    output logic [2:0] alu_control,
    output logic       illegal
);

    logic       is_r;
    logic       is_alu;
    logic       funct_ok;
    logic [2:0] funct_ctrl;

    always_comb begin
        is_r       = (op == OP_R);
        is_alu     = is_r || (op == OP_I);
        funct_ok   = 1'b1;
        funct_ctrl = ALU_ADD;
        case (funct3)
            // Funct7_5 on I-type is immediate bits, so only R-type may select sub.
            3'b000:  funct_ctrl = (is_r && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b010:  funct_ctrl = ALU_SLT;
            3'b110:  funct_ctrl = ALU_OR;
            3'b111:  funct_ctrl = ALU_AND;
            default: funct_ok   = 1'b0;
        endcase
        illegal = is_alu && !funct_ok;

        case (alu_op)
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_FUNCT: alu_control = funct_ctrl;
            default:     alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore sequencer for the multicycle 8-bit RISC-V-subset datapath; advances
// one step per enabled clock and gates every write enable with en.
module multicycle_control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic       clock_reg,
    input  logic       reset,
    input  logic       en,
    input  logic [6:0] OP,
    input  logic [2:0] Funct3,
    input  logic       Funct7_5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [3:0] state,
    output logic       halted,
    output logic       instr_done
);

    state_t state_q;
    state_t state_d;
    aluop_t alu_op;
    logic   illegal;
    logic   pc_update;
    logic   branch;
    logic   mem_write_s;
    logic   ir_write_s;
    logic   reg_write_s;
    logic   write_ok;

    alu_decoder u_alu_decoder (
        .op          (OP),
        .funct3      (Funct3),
        .funct7_5    (Funct7_5),
        .alu_op      (alu_op),
        .alu_control (ALUControl),
        .illegal     (illegal)
    );

    always_ff @(posedge clock_reg or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (en) begin
            case (state_q)
                S_FETCH:  state_d = S_DECODE;
                S_DECODE: begin
                    case (OP)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_R:         state_d = illegal ? S_HALT : S_EXECUTER;
                        OP_I:         state_d = illegal ? S_HALT : S_EXECUTEI;
                        OP_BEQ:       state_d = S_BEQ;
                        default:      state_d = S_HALT;
                    endcase
                end
                S_MEMADR:   state_d = (OP == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  state_d = S_MEMWB;
                S_EXECUTER: state_d = S_ALUWB;
                S_EXECUTEI: state_d = S_ALUWB;
                S_HALT:     state_d = S_HALT;
                default:    state_d = S_FETCH;
            endcase
        end
    end

    always_comb begin
        AdrSrc      = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;
        pc_update   = 1'b0;
        branch      = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RD2;
        alu_op      = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                ir_write_s = 1'b1;
                pc_update  = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
            end
            // Branch target is precomputed here while the register file is read.
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc   = RES_DATA;
                reg_write_s = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_RD1;
                alu_op  = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB:    reg_write_s = 1'b1;
            S_BEQ: begin
                ALUSrcA = SRCA_RD1;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset is folded in so no write can slip out while the async reset is held.
    assign write_ok   = en & reset;
    assign PCWrite    = write_ok & (pc_update | (branch & Zero));
    assign MemWrite   = write_ok & mem_write_s;
    assign IRWrite    = write_ok & ir_write_s;
    assign RegWrite   = write_ok & reg_write_s;
    assign ImmSrc     = imm_src_for(OP);
    assign state      = state_q;
    assign halted     = (state_q == S_HALT);
    assign instr_done = write_ok & ((state_q == S_MEMWB) | (state_q == S_MEMWRITE) |
                                    (state_q == S_ALUWB) | (state_q == S_BEQ));

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed scenarios plus randomized
// instruction streams checked against a per-instruction step model.
module tb_multicycle_control_unit;

    logic       clock_reg = 1'b0;
    logic       reset;
    logic       en;
    logic [6:0] OP;
    logic [2:0] Funct3;
    logic       Funct7_5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;
    logic       halted, instr_done;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011;

    typedef struct packed {
        logic       pcw, adr, memw, irw, regw;
        logic [1:0] res, srca, srcb;
        logic [2:0] aluc;
        logic [1:0] imm;
        logic       hlt;
    } ctrl_t;

    ctrl_t got;
    assign got = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ALUControl, ImmSrc, halted};

    multicycle_control_unit dut (
        .clock_reg (clock_reg), .reset (reset), .en (en), .OP (OP),
        .Funct3 (Funct3), .Funct7_5 (Funct7_5), .Zero (Zero),
        .PCWrite (PCWrite), .AdrSrc (AdrSrc), .MemWrite (MemWrite),
        .IRWrite (IRWrite), .RegWrite (RegWrite), .ResultSrc (ResultSrc),
        .ALUSrcA (ALUSrcA), .ALUSrcB (ALUSrcB), .ALUControl (ALUControl),
        .ImmSrc (ImmSrc), .state (state), .halted (halted), .instr_done (instr_done)
    );

    always #5 clock_reg = ~clock_reg;

    // ---------------- reference model ----------------
    function automatic int instr_len(input logic [6:0] op);
        case (op)
            LW:      return 5;
            SW, RT, IT: return 4;
            BEQ:     return 3;
            default: return 0;
        endcase
    endfunction

    // State visited at enabled step k of one instruction.
    function automatic int model_state(input logic [6:0] op, input int k);
        if (k == 0) return 0;
        if (k == 1) return 1;
        case (op)
            LW:      return (k == 2) ? 2 : (k == 3) ? 3 : 4;
            SW:      return (k == 2) ? 2 : 5;
            RT:      return (k == 2) ? 6 : 7;
            IT:      return (k == 2) ? 8 : 7;
            BEQ:     return 9;
            default: return 15;
        endcase
    endfunction

    function automatic logic [2:0] model_alu(input logic [6:0] op, input logic [2:0] f3,
                                             input logic f7);
        case (f3)
            3'b000:  return (op == RT && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic ctrl_t model_ctrl(input int st, input logic [6:0] op,
                                         input logic [2:0] f3, input logic f7,
                                         input logic z, input logic e);
        ctrl_t c;
        c = '0;
        c.imm = (op == SW) ? 2'b01 : (op == BEQ) ? 2'b10 : 2'b00;
        case (st)
            0:  begin c.irw = e; c.pcw = e; c.srcb = 2'b10; c.res = 2'b10; end
            1:  begin c.srca = 2'b01; c.srcb = 2'b01; end
            2:  begin c.srca = 2'b10; c.srcb = 2'b01; end
            3:  c.adr = 1'b1;
            4:  begin c.res = 2'b01; c.regw = e; end
            5:  begin c.adr = 1'b1; c.memw = e; end
            6:  begin c.srca = 2'b10; c.aluc = model_alu(op, f3, f7); end
            7:  c.regw = e;
            8:  begin c.srca = 2'b10; c.srcb = 2'b01; c.aluc = model_alu(op, f3, f7); end
            9:  begin c.srca = 2'b10; c.aluc = 3'b001; c.pcw = e & z; end
            15: c.hlt = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic advance();
        @(posedge clock_reg);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clock_reg);
        #1;
        en = 1'b0;
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0; en = 1'b1; OP = LW; Funct3 = 3'b000; Funct7_5 = 1'b0; Zero = 1'b0;
        #1;
        tests_run++;
        if (state !== 4'd0) begin
            tests_failed++; $display("FAIL reset_state got=%0d exp=0", state);
        end
        @(negedge clock_reg);
        tests_run++;
        if ({PCWrite, IRWrite, RegWrite, MemWrite, halted, instr_done} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_writes got=%b exp=000000",
                     {PCWrite, IRWrite, RegWrite, MemWrite, halted, instr_done});
        end
        tests_run++;
        if (ALUSrcB !== 2'b10 || ResultSrc !== 2'b10) begin
            tests_failed++; $display("FAIL reset_muxes got=%b/%b exp=10/10", ALUSrcB, ResultSrc);
        end
        advance();
        reset = 1'b1;
        @(negedge clock_reg);
        tests_run++;
        if ({IRWrite, PCWrite, ALUSrcB, state} !== {1'b1, 1'b1, 2'b10, 4'd0}) begin
            tests_failed++;
            $display("FAIL reset_release got=%b exp=%b", {IRWrite, PCWrite, ALUSrcB, state},
                     {1'b1, 1'b1, 2'b10, 4'd0});
        end
        advance();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        OP = LW; en = 1'b1;
        repeat (3) advance();
        tests_run++;
        if (state !== 4'd3) begin
            tests_failed++; $display("FAIL midreset_pre got=%0d exp=3", state);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (state !== 4'd0) begin
            tests_failed++; $display("FAIL midreset_async got=%0d exp=0", state);
        end
        @(negedge clock_reg);
        tests_run++;
        if ({RegWrite, MemWrite, PCWrite, IRWrite} !== 4'b0) begin
            tests_failed++;
            $display("FAIL midreset_writes got=%b exp=0000", {RegWrite, MemWrite, PCWrite, IRWrite});
        end
        advance();
        reset = 1'b1;
        @(negedge clock_reg);
        tests_run++;
        if ({IRWrite, PCWrite, ALUSrcB} !== 4'b1110) begin
            tests_failed++;
            $display("FAIL midreset_fetch got=%b exp=1110", {IRWrite, PCWrite, ALUSrcB});
        end
        advance();
    endtask

    task automatic test_lw();
        int exp_s[6] = '{0, 1, 2, 3, 4, 0};
        int dones = 0;
        apply_reset();
        OP = LW; Funct3 = 3'b010; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock_reg);
            tests_run++;
            if (state !== exp_s[i][3:0] || RegWrite !== (i == 4) ||
                (ResultSrc == 2'b01) !== (i == 4)) begin
                tests_failed++;
                $display("FAIL lw_step%0d got st=%0d rw=%b rs=%b exp st=%0d rw=%b",
                         i, state, RegWrite, ResultSrc, exp_s[i], (i == 4));
            end
            if (i < 5 && instr_done) dones++;
            advance();
        end
        tests_run++;
        if (dones !== 1) begin
            tests_failed++; $display("FAIL lw_done_pulses got=%0d exp=1", dones);
        end
    endtask

    task automatic test_alu_decode();
        logic [6:0] ops[6]  = '{RT, IT, RT, RT, RT, IT};
        logic [2:0] f3s[6]  = '{3'b000, 3'b000, 3'b010, 3'b110, 3'b111, 3'b110};
        logic [3:0] exst[6] = '{4'd6, 4'd8, 4'd6, 4'd6, 4'd6, 4'd8};
        logic [2:0] exal[6] = '{3'b001, 3'b000, 3'b101, 3'b011, 3'b010, 3'b011};
        for (int i = 0; i < 6; i++) begin
            apply_reset();
            OP = ops[i]; Funct3 = f3s[i]; Funct7_5 = 1'b1; en = 1'b1;
            advance();
            advance();
            @(negedge clock_reg);
            tests_run++;
            if (state !== exst[i] || ALUControl !== exal[i]) begin
                tests_failed++;
                $display("FAIL alu_case%0d got st=%0d alu=%b exp st=%0d alu=%b",
                         i, state, ALUControl, exst[i], exal[i]);
            end
            advance();
        end
    endtask

    task automatic test_beq();
        for (int zi = 0; zi < 2; zi++) begin
            logic z;
            z = (zi == 0);
            apply_reset();
            OP = BEQ; en = 1'b1; Zero = 1'b0;
            advance();
            advance();
            Zero = z;
            @(negedge clock_reg);
            tests_run++;
            if (state !== 4'd9 || PCWrite !== z || ALUControl !== 3'b001) begin
                tests_failed++;
                $display("FAIL beq_z%0b got st=%0d pcw=%b alu=%b exp st=9 pcw=%b alu=001",
                         z, state, PCWrite, ALUControl, z);
            end
            Zero = ~z;
            #1;
            tests_run++;
            if (PCWrite !== ~z) begin
                tests_failed++; $display("FAIL beq_zero_comb got=%b exp=%b", PCWrite, ~z);
            end
            Zero = z;
            advance();
            @(negedge clock_reg);
            tests_run++;
            if (state !== 4'd0) begin
                tests_failed++; $display("FAIL beq_return got=%0d exp=0", state);
            end
            advance();
        end
    endtask

    task automatic test_en_hold();
        logic       ens[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] exst[7] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd0};
        logic       exmw[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        apply_reset();
        OP = SW; Funct3 = 3'b010;
        for (int i = 0; i < 7; i++) begin
            en = ens[i];
            @(negedge clock_reg);
            tests_run++;
            if (state !== exst[i] || MemWrite !== exmw[i] ||
                (exst[i] == 4'd5 && AdrSrc !== 1'b1)) begin
                tests_failed++;
                $display("FAIL sw_en_step%0d got st=%0d mw=%b adr=%b exp st=%0d mw=%b",
                         i, state, MemWrite, AdrSrc, exst[i], exmw[i]);
            end
            advance();
        end
    endtask

    task automatic test_halt();
        logic [6:0] ops[2] = '{7'b1111111, RT};
        for (int c = 0; c < 2; c++) begin
            apply_reset();
            OP = ops[c]; Funct3 = 3'b001; en = 1'b1;
            advance();
            advance();
            for (int i = 0; i < 10; i++) begin
                @(negedge clock_reg);
                tests_run++;
                if (state !== 4'd15 || halted !== 1'b1 ||
                    {PCWrite, IRWrite, RegWrite, MemWrite, instr_done} !== 5'b0) begin
                    tests_failed++;
                    $display("FAIL halt_case%0d_cyc%0d got st=%0d h=%b we=%b exp st=15 h=1 we=0",
                             c, i, state, halted, {PCWrite, IRWrite, RegWrite, MemWrite, instr_done});
                end
                advance();
            end
        end
        apply_reset();
        @(negedge clock_reg);
        tests_run++;
        if (state !== 4'd0 || halted !== 1'b0) begin
            tests_failed++; $display("FAIL halt_recover got st=%0d h=%b exp st=0 h=0", state, halted);
        end
        advance();
    endtask

    task automatic test_random();
        logic [6:0] cls[5]   = '{LW, SW, RT, IT, BEQ};
        logic [2:0] legal[4] = '{3'b000, 3'b010, 3'b110, 3'b111};
        apply_reset();
        for (int n = 0; n < 60; n++) begin
            int    k;
            int    len;
            int    guard;
            int    st;
            ctrl_t exp;
            logic  exp_done;
            OP       = cls[$urandom_range(0, 4)];
            Funct7_5 = 1'($urandom_range(0, 1));
            Funct3   = (OP == RT || OP == IT) ? legal[$urandom_range(0, 3)]
                                              : 3'($urandom_range(0, 7));
            len   = instr_len(OP);
            k     = 0;
            guard = 0;
            while (k < len && guard < 100) begin
                en   = ($urandom_range(0, 3) != 0);
                Zero = 1'($urandom_range(0, 1));
                @(negedge clock_reg);
                st       = model_state(OP, k);
                exp      = model_ctrl(st, OP, Funct3, Funct7_5, Zero, en);
                exp_done = en && (k == len - 1);
                tests_run++;
                if (state !== st[3:0] || got !== exp || instr_done !== exp_done) begin
                    tests_failed++;
                    $display("FAIL rand_i%0d_k%0d got st=%0d ctl=%h done=%b exp st=%0d ctl=%h done=%b",
                             n, k, state, got, instr_done, st, exp, exp_done);
                end
                if (en) k++;
                advance();
                guard++;
            end
            if (guard >= 100) begin
                tests_run++;
                tests_failed++;
                $display("FAIL rand_i%0d_budget got=%0d steps exp=%0d", n, k, len);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_lw();
        test_alu_decode();
        test_beq();
        test_en_hold();
        test_halt();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
